// File: rtl/lifo.sv
// lifo: single-clock last-in/first-out stack with a registered pop port and a full flag.
// Define LIFO_EMPTY_EN to add an `empty` output decoded from the occupancy counter.
module lifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             write,
   input  logic [WIDTH-1:0] datain,
   input  logic             read,
   output logic [WIDTH-1:0] dataout,
   output logic             val,
   output logic             full
`ifdef LIFO_EMPTY_EN
   ,
   output logic             empty
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_m1;
   logic [AW-1:0]    wr_addr;
   logic [AW-1:0]    rd_addr;
   logic             push_ok;
   logic             pop_ok;
   logic             bypass;

   // Flow control: there is no ready. A push offered while full is silently
   // dropped; dataout is meaningful only in the cycle where val is high.
   assign cnt_m1  = cnt - CW'(1);
   assign wr_addr = cnt[AW-1:0];
   assign rd_addr = cnt_m1[AW-1:0];
   assign bypass  = write && read;
   assign push_ok = write && !read && !full;
   assign pop_ok  = read && !write && (cnt != '0);

   assign full = (cnt == CW'(DEPTH));
`ifdef LIFO_EMPTY_EN
   assign empty = (cnt == '0);
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt     <= '0;
         dataout <= '0;
         val     <= 1'b0;
      end else begin
         val <= 1'b0;
         if (bypass) begin
            dataout <= datain;
            val     <= 1'b1;
         end else if (push_ok) begin
            cnt <= cnt + CW'(1);
         end else if (pop_ok) begin
            dataout <= mem[rd_addr];
            cnt     <= cnt_m1;
            val     <= 1'b1;
         end
      end
   end

   // Storage is written only on an accepted push, so an idle datain never lands in the array.
   always_ff @(posedge clk) begin
      if (reset && push_ok) begin
         mem[wr_addr] <= datain;
      end
   end

endmodule

// File: tb/tb_lifo.sv
// tb_lifo: directed test-plan steps followed by random push/pop traffic,
// checked against a queue-based stack model.
module tb_lifo;

   localparam int WIDTH = 10;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             write;
   logic [WIDTH-1:0] datain;
   logic             read;
   logic [WIDTH-1:0] dataout;
   logic             val;
   logic             full;
   logic             empty;

   logic [WIDTH-1:0] stk[$];
   logic [WIDTH-1:0] exp_dout;
   logic             exp_val;
   int               vectors = 0;
   int               miscompares = 0;

   always #5 clk = ~clk;

   lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .write   (write),
      .datain  (datain),
      .read    (read),
      .dataout (dataout),
      .val     (val),
      .full    (full)
`ifdef LIFO_EMPTY_EN
      ,
      .empty   (empty)
`endif
   );

`ifndef LIFO_EMPTY_EN
   assign empty = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_dataout"}, 32'(dataout), 32'(exp_dout));
      check({tag, "_val"}, 32'(val), 32'(exp_val));
      check({tag, "_full"}, 32'(full), 32'(stk.size() == DEPTH));
`ifdef LIFO_EMPTY_EN
      check({tag, "_empty"}, 32'(empty), 32'(stk.size() == 0));
`endif
   endtask

   // One clock of traffic; inactive datain is driven to X on purpose.
   task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d, input string tag);
      @(negedge clk);
      write  = w;
      read   = r;
      datain = w ? d : 'x;
      @(posedge clk);
      exp_val = 1'b0;
      if (w && r) begin
         exp_dout = d;
         exp_val  = 1'b1;
      end else if (w) begin
         if (stk.size() < DEPTH) stk.push_back(d);
      end else if (r) begin
         if (stk.size() > 0) begin
            exp_dout = stk.pop_back();
            exp_val  = 1'b1;
         end
      end
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input logic w, input logic r);
      @(negedge clk);
      reset  = 1'b0;
      write  = w;
      read   = r;
      datain = WIDTH'($urandom);
      @(posedge clk);
      stk.delete();
      exp_dout = '0;
      exp_val  = 1'b0;
      #1;
      check_all("reset");
      @(negedge clk);
      reset = 1'b1;
      write = 1'b0;
      read  = 1'b0;
   endtask

   initial begin
      reset    = 1'b0;
      write    = 1'b0;
      read     = 1'b0;
      datain   = '0;
      exp_dout = '0;
      exp_val  = 1'b0;
      repeat (2) @(posedge clk);
      do_reset(1'b1, 1'b1);

      // Fill, overflow, drain.
      step(1, 0, 10'h001, "push1");
      step(1, 0, 10'h002, "push2");
      step(1, 0, 10'h004, "push3");
      check("pre_full", 32'(full), 32'(0));
      step(1, 0, 10'h008, "push4");
      check("full_after_4", 32'(full), 32'(1));
      for (int i = 0; i < 3; i++) step(1, 0, 10'h3FF, "push_drop");
      step(0, 1, '0, "pop1");
      check("pop1_word", 32'(dataout), 32'h008);
      check("full_drop", 32'(full), 32'(0));
      step(0, 1, '0, "pop2");
      step(0, 1, '0, "pop3");
      step(0, 1, '0, "pop4");
      check("pop4_word", 32'(dataout), 32'h001);
      step(0, 1, '0, "pop_empty");
      check("pop_empty_hold", 32'(dataout), 32'h001);
      check("pop_empty_val", 32'(val), 32'(0));

      // Bypass with two words stored.
      step(1, 0, 10'h0A1, "bp_push1");
      step(1, 0, 10'h0B2, "bp_push2");
      step(1, 1, 10'h16B, "bypass");
      check("bypass_word", 32'(dataout), 32'h16B);
      step(0, 1, '0, "bp_pop");
      check("bp_pop_word", 32'(dataout), 32'h0B2);
      step(0, 0, '0, "idle");

      // Bypass on a full stack, then reset mid-sequence.
      step(1, 0, 10'h111, "f_push1");
      step(1, 0, 10'h122, "f_push2");
      step(1, 0, 10'h133, "f_push3");
      step(1, 1, 10'h2AA, "bypass_full");
      step(1, 0, 10'h0C3, "r_push");
      do_reset(1'b0, 1'b1);
      step(0, 1, '0, "pop_after_reset");
      check("par_val", 32'(val), 32'(0));
      check("par_dout", 32'(dataout), 32'(0));

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset(1'($urandom), 1'($urandom));
         end else begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 WIDTH'($urandom), "random");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lifo.md
# lifo

Synchronous last-in/first-out stack for datapath buffering. Pushes a word on `write` and pops the most recent word on `read`, both on the same clock edge. The popped word is registered and qualified by `val`. The `full` flag provides backpressure to the producer. The stack is a single-clock block with no clock-domain crossing, intended for local scratch storage inside a pipeline stage.

## Interface
- `WIDTH`, default 10: data word width in bits.
- `DEPTH`, default 4: number of storage entries; any value ≥2.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `write`  input  1  push request.
- `datain`  input  WIDTH  word to push.
- `read`  input  1  pop request.
- `dataout`  output  WIDTH  registered popped word.
- `val`  output  1  high for one cycle when `dataout` was updated by a pop.
- `full`  output  1  high when the stack holds `DEPTH` words.

## Operation
- Internal state:
  - `DEPTH × WIDTH` storage array.
  - Occupancy counter `cnt`, range 0..DEPTH, width `$clog2(DEPTH+1)`.
- Push only (`write=1`, `read=0`):
  - If `cnt<DEPTH`: `mem[cnt]<=datain`, `cnt<=cnt+1`.
  - If full: the write is dropped and the stack is unchanged.
  - `val<=0`.
- Pop only (`read=1`, `write=0`):
  - If `cnt>0`: `dataout<=mem[cnt-1]`, `cnt<=cnt-1`, `val<=1`.
  - If empty: `val<=0` and `dataout` holds its previous value.
- Simultaneous push and pop (`write=1`, `read=1`), at any occupancy including empty and full:
  - Bypass: `dataout<=datain`, `val<=1`.
  - `cnt` and the storage array are unchanged.
- Idle (`write=0`, `read=0`): `val<=0`; all other state holds.
- `full = (cnt==DEPTH)`. This is decoded from the registered counter with no input-to-output combinational path.
- X on an inactive `datain` must not propagate into the stored state.

## Timing
- Reset (`reset=0` at a rising edge):
  - `cnt<=0`, `dataout<=0`, `val<=0`, so `full=0`.
  - Storage contents are don't-care.
  - Reset overrides any simultaneous `read` or `write`.
- Push latency: `full` reflects a push one edge after the push is sampled.
- Pop latency: `dataout`/`val` are valid one edge after `read` is sampled.
  - `val` is a single-cycle pulse per accepted pop or bypass.
  - Back-to-back pops produce one word per cycle.
- Reset mid-sequence empties the stack. A pop in the cycle after reset returns `val=0`.
- No handshake beyond the flags:
  - The producer must not rely on a write being accepted while `full=1`.
  - The consumer qualifies `dataout` with `val`.

## Configuration
- `LIFO_EMPTY_EN`:
  - Defined: adds output port `empty` (1 bit) `= (cnt==0)`, registered-decoded like `full`. Its reset value is 1.
  - Undefined: no `empty` port; behaviour is otherwise identical.

## Test plan
- Reset, then 4 pushes of 0x001, 0x002, 0x004, 0x008 (DEPTH=4) -> `full` rises one edge after the 4th push; `val=0` throughout.
- Continue from the full stack: 3 extra pushes of 0x3FF while full -> dropped. Then 4 pops -> `dataout` 0x008, 0x004, 0x002, 0x001 with `val=1` each cycle; `full` drops after the first pop.
- Pop on empty stack -> `val=0`, `dataout` holds 0x001.
- Simultaneous `read=1`, `write=1`, `datain=0x16B` on a stack holding 2 words -> next cycle `dataout=0x16B`, `val=1`. A following pop returns the original top word.
- Push 2 words, assert `reset=0` for one edge, then pop -> `val=0`, `dataout=0`, `full=0`.
- With `LIFO_EMPTY_EN` defined: `empty=1` after reset, 0 after one push, and 1 again after the matching pop.
